// File: rtl/host_cmd_pkg.sv
// rtl/host_cmd_pkg.sv - opcodes, command/state encodings and frame/response lengths for host_cmd_master
package host_cmd_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [2:0] FRAME_LEN_WR      = 3'd3;
    localparam logic [2:0] FRAME_LEN_RD      = 3'd2;
    localparam logic [2:0] FRAME_LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] FRAME_LEN_ALU_NOP = 3'd2;

    localparam logic [1:0] RSP_LEN_WR      = 2'd0;
    localparam logic [1:0] RSP_LEN_RD      = 2'd1;
    localparam logic [1:0] RSP_LEN_ALU_OP  = 2'd2;
    localparam logic [1:0] RSP_LEN_ALU_NOP = 2'd2;

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        case (t)
            CMD_WR:     return FRAME_LEN_WR;
            CMD_RD:     return FRAME_LEN_RD;
            CMD_ALU_OP: return FRAME_LEN_ALU_OP;
            default:    return FRAME_LEN_ALU_NOP;
        endcase
    endfunction

    function automatic logic [1:0] rsp_len(input cmd_type_e t);
        case (t)
            CMD_WR:     return RSP_LEN_WR;
            CMD_RD:     return RSP_LEN_RD;
            CMD_ALU_OP: return RSP_LEN_ALU_OP;
            default:    return RSP_LEN_ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_rsp_timer.sv
// rtl/host_cmd_rsp_timer.sv - idle-cycle counter that flags a stalled response
module host_cmd_rsp_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + W'(1);
        end
    end

    // Fires on the last allowed idle cycle so the caller leaves exactly TIMEOUT_CYCLES after entry.
    assign expired = !clear && (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/host_cmd_master.sv
// rtl/host_cmd_master.sv - serialises one command to UART TX and assembles the RX response
// Optional response timeout enabled by defining HOST_CMD_MASTER_TIMEOUT_EN.
module host_cmd_master
    import host_cmd_pkg::*;
#(
    parameter int FRAME_WIDTH         = 8,
    parameter int ALU_DATA_WIDTH      = 16,
    parameter int ALU_FUNC_WIDTH      = 4,
    parameter int REG_FILE_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES      = 65535
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_type,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [FRAME_WIDTH-1:0]         cmd_data,
    input  logic [FRAME_WIDTH-1:0]         cmd_opa,
    input  logic [FRAME_WIDTH-1:0]         cmd_opb,
    input  logic [ALU_FUNC_WIDTH-1:0]      cmd_func,
    output logic [FRAME_WIDTH-1:0]         tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    input  logic [FRAME_WIDTH-1:0]         rx_data,
    input  logic                           rx_valid,
    output logic                           rsp_valid,
    output logic [ALU_DATA_WIDTH-1:0]      rsp_data,
    output logic                           rsp_timeout,
    output logic                           rx_unexpected
);

    if (ALU_DATA_WIDTH < 2 * FRAME_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("host_cmd_master: result must hold two bytes and timeout must be positive");
    end

    state_e                           state_q, state_d;
    cmd_type_e                        type_q;
    logic [REG_FILE_ADDR_WIDTH-1:0]   addr_q;
    logic [FRAME_WIDTH-1:0]           data_q, opa_q, opb_q;
    logic [ALU_FUNC_WIDTH-1:0]        func_q;
    logic [2:0]                       idx_q;
    logic [1:0]                       rx_cnt_q;
    logic [ALU_DATA_WIDTH-1:0]        rsp_q;
    logic [FRAME_WIDTH-1:0]           tx_byte;
    logic                             tx_hs, last_hs, rx_take, timeout_hit;

    always_comb begin
        tx_byte = '0;
        case (type_q)
            CMD_WR: case (idx_q)
                3'd0:    tx_byte = FRAME_WIDTH'(OP_WR);
                3'd1:    tx_byte = FRAME_WIDTH'(addr_q);
                default: tx_byte = data_q;
            endcase
            CMD_RD: tx_byte = (idx_q == 3'd0) ? FRAME_WIDTH'(OP_RD) : FRAME_WIDTH'(addr_q);
            CMD_ALU_OP: case (idx_q)
                3'd0:    tx_byte = FRAME_WIDTH'(OP_ALU_OP);
                3'd1:    tx_byte = opa_q;
                3'd2:    tx_byte = opb_q;
                default: tx_byte = FRAME_WIDTH'(func_q);
            endcase
            default: tx_byte = (idx_q == 3'd0) ? FRAME_WIDTH'(OP_ALU_NOP) : FRAME_WIDTH'(func_q);
        endcase
    end

    assign tx_hs   = (state_q == ST_SEND) && tx_ready;
    assign last_hs = tx_hs && (idx_q == frame_len(type_q) - 3'd1);
    // A byte arriving with the final TX handshake is already the first response byte.
    assign rx_take = rx_valid && (((state_q == ST_WAIT_RSP)) ||
                                  (last_hs && rsp_len(type_q) != 2'd0));

`ifdef HOST_CMD_MASTER_TIMEOUT_EN
    logic timed_out_q;

    host_cmd_rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk    (CLK),
        .resetn (RST),
        .clear  ((state_q != ST_WAIT_RSP) || rx_valid),
        .expired(timeout_hit)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            timed_out_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            timed_out_q <= 1'b0;
        end else if (timeout_hit) begin
            timed_out_q <= 1'b1;
        end
    end

    assign rsp_timeout = (state_q == ST_DONE) && timed_out_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_SEND;
            ST_SEND: begin
                if (last_hs) begin
                    if (rsp_len(type_q) == 2'd0 || (rx_valid && rsp_len(type_q) == 2'd1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if ((rx_valid && rx_cnt_q + 2'd1 == rsp_len(type_q)) || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            type_q   <= CMD_WR;
            addr_q   <= '0;
            data_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            func_q   <= '0;
            idx_q    <= '0;
            rx_cnt_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && cmd_valid) begin
                type_q   <= cmd_type_e'(cmd_type);
                addr_q   <= cmd_addr;
                data_q   <= cmd_data;
                opa_q    <= cmd_opa;
                opb_q    <= cmd_opb;
                func_q   <= cmd_func;
                idx_q    <= '0;
                rx_cnt_q <= '0;
                rsp_q    <= '0;
            end
            if (tx_hs) begin
                idx_q <= idx_q + 3'd1;
            end
            if (rx_take) begin
                if (rx_cnt_q == 2'd0) begin
                    rsp_q[FRAME_WIDTH-1:0] <= rx_data;
                end else begin
                    rsp_q[2*FRAME_WIDTH-1:FRAME_WIDTH] <= rx_data;
                end
                rx_cnt_q <= rx_cnt_q + 2'd1;
            end
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign tx_valid      = (state_q == ST_SEND);
    assign tx_data       = tx_valid ? tx_byte : '0;
    assign rsp_valid     = (state_q == ST_DONE);
    assign rsp_data      = rsp_q;
    assign rx_unexpected = rx_valid && !rx_take;

endmodule

// File: tb/tb_host_cmd_master.sv
// tb/tb_host_cmd_master.sv - randomized self-checking bench for host_cmd_master
module tb_host_cmd_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data, cmd_opa, cmd_opb;
    logic [3:0]  cmd_func;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout, rx_unexpected;

    int checks = 0;
    int errors = 0;

    host_cmd_master #(
        .FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .ALU_FUNC_WIDTH(4),
        .REG_FILE_ADDR_WIDTH(4), .TIMEOUT_CYCLES(20)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_opa(cmd_opa),
        .cmd_opb(cmd_opb), .cmd_func(cmd_func),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .rx_unexpected(rx_unexpected)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Frame bytes and expected result come straight from the protocol tables.
    task automatic run_cmd(input int t, input logic [3:0] addr, input logic [7:0] data,
                           input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] func,
                           input logic [7:0] r0, input logic [7:0] r1,
                           input int gap, input bit early, input int stall);
        logic [7:0]  exp_tx[$];
        logic [15:0] exp_rsp;
        int rlen, idx, cyc, got;
        exp_tx = {};
        case (t)
            0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(data); end
            1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
            2: begin exp_tx.push_back(8'hCC); exp_tx.push_back(opa); exp_tx.push_back(opb);
                     exp_tx.push_back({4'h0, func}); end
            default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, func}); end
        endcase
        rlen    = (t == 0) ? 0 : (t == 1) ? 1 : 2;
        exp_rsp = (rlen == 0) ? 16'h0000 : (rlen == 1) ? {8'h00, r0} : {r1, r0};

        cmd_valid = 1'b1; cmd_type = 2'(t); cmd_addr = addr; cmd_data = data;
        cmd_opa = opa; cmd_opb = opb; cmd_func = func;
        tx_ready = 1'b0; rx_valid = 1'b0;
        #1;
        check("accept_ready", cmd_ready, 1);
        tick;

        // Garbage on the command inputs while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1)); cmd_type = 2'($urandom); cmd_addr = 4'($urandom);
        cmd_data = 8'($urandom); cmd_opa = 8'($urandom); cmd_opb = 8'($urandom); cmd_func = 4'($urandom);

        idx = 0; cyc = 0; got = 0;
        while (idx < exp_tx.size() && cyc < 200) begin
            case (stall)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (cyc % 2 == 0);
            endcase
            rx_valid = early && rlen > 0 && idx == exp_tx.size() - 1 && tx_ready;
            rx_data  = r0;
            #1;
            if (cyc == 0) check("first_tx_valid", tx_valid, 1);
            check("busy_ready", cmd_ready, 0);
            check($sformatf("tx_byte%0d", idx), tx_data, exp_tx[idx]);
            check("rx_unexp_send", rx_unexpected, 0);
            if (tx_valid && tx_ready) begin
                if (rx_valid) got = 1;
                idx++;
            end
            tick;
            cyc++;
        end
        check("send_done", idx, exp_tx.size());
        if (stall == 0) check("send_cycles", cyc, exp_tx.size());
        tx_ready = 1'b0; rx_valid = 1'b0;

        while (got < rlen) begin
            for (int g = 0; g < gap; g++) begin
                #1;
                check("rsp_early", rsp_valid, 0);
                tick;
            end
            rx_valid = 1'b1;
            rx_data  = (got == 0) ? r0 : r1;
            #1;
            check("rx_unexp_wait", rx_unexpected, 0);
            check("rsp_early", rsp_valid, 0);
            tick;
            rx_valid = 1'b0;
            got++;
        end
        cmd_valid = 1'b0;
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_rsp);
        check("rsp_timeout", rsp_timeout, 0);
        check("done_ready", cmd_ready, 0);
        tick;
        #1;
        check("ready_again", cmd_ready, 1);
        check("rsp_single", rsp_valid, 0);
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        RST = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_data = '0;
        cmd_opa = '0; cmd_opb = '0; cmd_func = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) tick;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rx_unexp", rx_unexpected, 0);
        RST = 1'b1;
        tick;

        run_cmd(0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 0, 1'b0, 0);
        run_cmd(1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0, 8'h81, 8'h00, 10, 1'b0, 0);
        run_cmd(2, 4'd0, 8'h00, 8'h0A, 8'h05, 4'd0, 8'h0F, 8'h00, 0, 1'b0, 0);
        run_cmd(3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd2, 8'h32, 8'h00, 0, 1'b0, 2);
        run_cmd(1, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0, 8'h5A, 8'h00, 0, 1'b1, 0);
        run_cmd(2, 4'd0, 8'h00, 8'hFF, 8'h01, 4'd7, 8'h34, 8'h12, 3, 1'b1, 0);

        rx_valid = 1'b1; rx_data = 8'h55;
        #1;
        check("idle_rx_unexp", rx_unexpected, 1);
        check("idle_rx_ready", cmd_ready, 1);
        tick;
        rx_valid = 1'b0;
        #1;
        check("idle_rx_pulse", rx_unexpected, 0);
        check("idle_rx_state", cmd_ready, 1);
        tick;

        cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 4'd5; cmd_data = 8'h3C;
        tick;
        cmd_valid = 1'b0; tx_ready = 1'b1;
        #1;
        check("abort_byte0", tx_data, 8'hAA);
        tick;
        RST = 1'b0;
        #1;
        check("abort_byte1", tx_data, 8'h05);
        tick;
        RST = 1'b1; tx_ready = 1'b0;
        #1;
        check("abort_ready", cmd_ready, 1);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_rsp", rsp_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            #1;
            check("abort_no_rsp", rsp_valid, 0);
        end
        tick;

`ifdef HOST_CMD_MASTER_TIMEOUT_EN
        cmd_valid = 1'b1; cmd_type = 2'd1; cmd_addr = 4'd3;
        tick;
        cmd_valid = 1'b0; tx_ready = 1'b1;
        tick;
        tick;
        tx_ready = 1'b0;
        n = 1;
        #1;
        while (!rsp_valid && n < 40) begin
            tick;
            #1;
            n++;
        end
        check("timeout_latency", n, 21);
        check("timeout_flag", rsp_timeout, 1);
        check("timeout_data", rsp_data, 0);
        tick;
        #1;
        check("timeout_ready", cmd_ready, 1);
        check("timeout_flag_clr", rsp_timeout, 0);
        tick;
`endif

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 3);
            run_cmd(n, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                    8'($urandom), 8'($urandom), $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
